// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared state encoding and default addresses for the sprite DMA.
package oam_dma_pkg;
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} state_t;
  localparam logic [15:0] OAM_DMA_TRIGGER = 16'h4014;
  localparam logic [15:0] OAM_DMA_DEST = 16'h2004;
endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU snoop/halt handshake plus the DMA side of the system bus.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic cpu_rw;
  logic [7:0] cpu_data;
  logic cpu_halt;
  logic cpu_halt_ack;
  logic dma_active;
  logic [15:0] dma_addr;
  logic dma_rw;
  logic [7:0] dma_data_out;
  logic [7:0] dma_data_in;
  logic busy;
  modport master (
    input cpu_addr, cpu_rw, cpu_data, cpu_halt_ack, dma_data_in,
    output cpu_halt, dma_active, dma_addr, dma_rw, dma_data_out, busy
  );
  modport slave (
    output cpu_addr, cpu_rw, cpu_data, cpu_halt_ack, dma_data_in,
    input cpu_halt, dma_active, dma_addr, dma_rw, dma_data_out, busy
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: 2A03-style sprite DMA, halts the CPU and copies LENGTH bytes from page $XX00 to DEST_ADDR.
// OAM_DMA_PARITY_ALIGN_EN adds the parity toggle and the odd-cycle ALIGN dummy read.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_TRIGGER,
  parameter logic [15:0] DEST_ADDR = OAM_DMA_DEST,
  parameter int LENGTH = 256
) (
  input logic clock,
  input logic nreset,
  oam_dma_if.master bus
);
  localparam logic [8:0] LEN = 9'(LENGTH);
  state_t state, state_nx;
  logic [7:0] page, rdata;
  logic [8:0] idx, idx_inc;
  logic trig, go_align, active;
  assign trig = state == IDLE && bus.cpu_addr == TRIGGER_ADDR && !bus.cpu_rw;
  assign idx_inc = idx + 9'd1;
`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic parity;
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) parity <= 1'b0;
    else parity <= ~parity;
  assign go_align = parity;
`else
  assign go_align = 1'b0;
`endif
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) state <= IDLE;
    else state <= state_nx;
  // read data is registered by peripherals on negedge, so it is stable at the edge ending READ
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      page <= '0;
      idx <= '0;
      rdata <= '0;
    end else begin
      if (trig) page <= bus.cpu_data;
      if (trig) idx <= '0;
      else if (state == WRITE) idx <= idx_inc;
      if (state == READ) rdata <= bus.dma_data_in;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = trig ? HALT : IDLE;
      HALT: state_nx = !bus.cpu_halt_ack ? HALT : go_align ? ALIGN : READ;
      ALIGN: state_nx = READ;
      READ: state_nx = WRITE;
      WRITE: state_nx = idx_inc < LEN ? READ : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign active = state inside {ALIGN, READ, WRITE};
  assign bus.dma_active = active;
  assign bus.cpu_halt = active || state == HALT;
  assign bus.busy = state != IDLE;
  assign bus.dma_rw = state != WRITE;
  assign bus.dma_addr = state == WRITE ? DEST_ADDR : active ? {page, idx[7:0]} : 16'h0000;
  assign bus.dma_data_out = state == WRITE ? rdata : 8'h00;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed checks of the sprite DMA, full-length instance plus a LENGTH=4 instance.
module tb_oam_dma;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DEST = 16'h2004;
  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic par_m;
  logic sel = 1'b0;
  int total = 0;
  int bad = 0;
  oam_dma_if b();
  oam_dma_if b4();
  oam_dma dut (.clock(clock), .nreset(nreset), .bus(b.master));
  oam_dma #(.LENGTH(4)) dut4 (.clock(clock), .nreset(nreset), .bus(b4.master));
  always #5 clock = ~clock;
  always @(posedge clock or negedge nreset)
    if (!nreset) par_m <= 1'b0;
    else par_m <= ~par_m;
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return a[7:0] ^ (a[15:8] - 8'h02);
  endfunction
  always @(negedge clock) if (b.dma_active && b.dma_rw) b.dma_data_in <= mem_rd(b.dma_addr);
  always @(negedge clock) if (b4.dma_active && b4.dma_rw) b4.dma_data_in <= mem_rd(b4.dma_addr);
  logic m_busy, m_halt, m_active, m_rw;
  logic [15:0] m_addr;
  logic [7:0] m_dout;
  assign m_busy = sel ? b4.busy : b.busy;
  assign m_halt = sel ? b4.cpu_halt : b.cpu_halt;
  assign m_active = sel ? b4.dma_active : b.dma_active;
  assign m_rw = sel ? b4.dma_rw : b.dma_rw;
  assign m_addr = sel ? b4.dma_addr : b.dma_addr;
  assign m_dout = sel ? b4.dma_data_out : b.dma_data_out;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_cpu(input logic [15:0] a, input logic rw, input logic [7:0] d);
    if (sel) begin b4.cpu_addr = a; b4.cpu_rw = rw; b4.cpu_data = d; end
    else begin b.cpu_addr = a; b.cpu_rw = rw; b.cpu_data = d; end
  endtask
  task automatic set_ack(input logic v);
    if (sel) b4.cpu_halt_ack = v;
    else b.cpu_halt_ack = v;
  endtask
  task automatic rst_chk(input string p);
    chk({p, "_halt"}, b.cpu_halt, 1'b0);
    chk({p, "_active"}, b.dma_active, 1'b0);
    chk({p, "_busy"}, b.busy, 1'b0);
    chk({p, "_addr"}, b.dma_addr, 16'h0000);
    chk({p, "_rw"}, b.dma_rw, 1'b1);
    chk({p, "_dout"}, b.dma_data_out, 8'h00);
  endtask
  task automatic run_xfer(input bit s, input logic [7:0] pg, input int len, input int hold,
                          input logic want_par, input int abort_at);
    int act = 0, wr = 0, rd = 0, hold_bad = 0, waddr_bad = 0, data_bad = 0, raddr_bad = 0;
    int exp_align;
    bit done = 0, aborted = 0, first_rw = 0, seen = 0;
    logic last_active = 1'b1, last_halt = 1'b1;
    sel = s;
    @(negedge clock) set_cpu(TRIG, 1'b0, pg);
    @(negedge clock) set_cpu(16'h0000, 1'b1, 8'h00);
    chk("trig_halt", m_halt, 1'b1);
    chk("trig_busy", m_busy, 1'b1);
    chk("trig_active", m_active, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (m_active !== 1'b0 || m_halt !== 1'b1 || m_addr !== 16'h0000) hold_bad++;
    end
    if (hold > 0) chk("hold_no_bus", hold_bad, 0);
    for (int i = 0; i < 2 && par_m !== want_par; i++) @(negedge clock);
`ifdef OAM_DMA_PARITY_ALIGN_EN
    exp_align = int'(par_m);
`else
    exp_align = 0;
`endif
    set_ack(1'b1);
    for (int i = 0; i < 2 * len + 20; i++) begin
      @(negedge clock);
      if (!m_busy) begin done = 1; break; end
      last_active = m_active;
      last_halt = m_halt;
      if (m_active) begin
        if (!seen) begin first_rw = m_rw; seen = 1; end
        act++;
        if (m_rw) begin
          rd++;
          if (m_addr !== {pg, wr[7:0]}) raddr_bad++;
        end else begin
          if (m_addr !== DEST) waddr_bad++;
          if (m_dout !== mem_rd({pg, wr[7:0]})) data_bad++;
          wr++;
        end
      end
      if (wr == 50) set_cpu(TRIG, 1'b0, 8'h05);
      if (wr == 51) set_cpu(16'h0000, 1'b1, 8'h00);
      if (wr == 60) set_ack(1'b0);
      if (abort_at >= 0 && wr == abort_at) begin
        #2 nreset = 1'b0;
        #1 rst_chk("abort");
        aborted = 1;
        break;
      end
    end
    set_ack(1'b0);
    set_cpu(16'h0000, 1'b1, 8'h00);
    if (!aborted) begin
      chk("timeout", done, 1'b1);
      chk("first_is_read", first_rw, 1'b1);
      chk("active_cycles", act, 2 * len + exp_align);
      chk("reads", rd, len + exp_align);
      chk("writes", wr, len);
      chk("read_addr_bad", raddr_bad, 0);
      chk("write_addr_bad", waddr_bad, 0);
      chk("write_data_bad", data_bad, 0);
      chk("done_active", last_active, 1'b0);
      chk("done_halt", last_halt, 1'b0);
      chk("idle_addr", m_addr, 16'h0000);
      chk("idle_rw", m_rw, 1'b1);
    end
  endtask
  initial begin
    b.cpu_addr = 16'h0000; b.cpu_rw = 1'b1; b.cpu_data = 8'h00; b.cpu_halt_ack = 1'b0;
    b4.cpu_addr = 16'h0000; b4.cpu_rw = 1'b1; b4.cpu_data = 8'h00; b4.cpu_halt_ack = 1'b0;
    b.dma_data_in = 8'h00;
    b4.dma_data_in = 8'h00;
    #12 rst_chk("reset");
    chk("reset_busy4", b4.busy, 1'b0);
    @(negedge clock) nreset = 1'b1;
    run_xfer(1'b0, 8'h02, 256, 10, 1'b0, -1);
    run_xfer(1'b0, 8'h02, 256, 0, 1'b1, -1);
    run_xfer(1'b0, 8'h02, 256, 0, 1'b0, 101);
    @(negedge clock) nreset = 1'b1;
    run_xfer(1'b0, 8'h02, 256, 0, 1'b0, -1);
    run_xfer(1'b1, 8'h01, 4, 0, 1'b1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/oam_dma.md
# oam_dma

Bus initiator that performs 2A03-style sprite DMA. On a CPU write to the trigger address it halts the CPU, takes the system address/data bus, and copies 256 bytes from page `$XX00` to a fixed destination register, one read/write pair per byte. It sits beside `cpu_2a03` in front of `peripherals`. A top-level mux selects DMA bus signals while `dma_active` is high.

## Interface
Parameters:
- `TRIGGER_ADDR`, default `16'h4014`: CPU write address that starts a transfer; the written byte is the source page.
- `DEST_ADDR`, default `16'h2004`: destination written once per byte.
- `LENGTH`, default `256`: bytes per transfer, range 1..256.

Ports:
- `clock`, in, 1: system clock, the same clock that drives the CPU and peripherals.
- `nreset`, in, 1: reset. Asynchronous, active-low.
- `cpu_addr`, in, 16: CPU address, snooped.
- `cpu_rw`, in, 1: CPU read/write (1 = read), snooped.
- `cpu_data`, in, 8: CPU write data, snooped.
- `cpu_halt`, out, 1: request that the CPU stall.
- `cpu_halt_ack`, in, 1: CPU is stalled and has released the bus.
- `dma_active`, out, 1: DMA owns the bus; bus mux select.
- `dma_addr`, out, 16: bus address.
- `dma_rw`, out, 1: bus read/write (1 = read).
- `dma_data_out`, out, 8: bus write data.
- `dma_data_in`, in, 8: bus read data from `peripherals`.
- `busy`, out, 1: high from trigger until completion.

## Operation
- Trigger condition: `cpu_addr == TRIGGER_ADDR`, `cpu_rw == 0`, and state is IDLE, sampled on posedge `clock`.
- On trigger, latch `cpu_data` into `page` and clear byte index `idx`.
- A trigger seen in any state other than IDLE is ignored and leaves `page` unchanged.
- Source address is `{page, idx[7:0]}`. `idx` never carries into `page`.
- States and transitions:
  - IDLE: wait for trigger.
  - HALT: assert `cpu_halt`; wait for `cpu_halt_ack`.
  - ALIGN: one dummy cycle. `dma_active` = 1, `dma_rw` = 1, `dma_addr` = source address; read data discarded.
  - READ: drive `dma_rw` = 1 and `dma_addr` = source address.
  - WRITE: drive `dma_rw` = 0, `dma_addr` = `DEST_ADDR`, `dma_data_out` = byte captured from `dma_data_in` at the end of READ. Then increment `idx`.
  - DONE: one cycle with `dma_active` = 0 and `cpu_halt` = 0, then go to IDLE.
- After WRITE, go to READ if `idx` (after increment) < `LENGTH`; otherwise go to DONE.
- A free-running 1-bit `parity` toggles every clock from reset (reset value 0).
- On `cpu_halt_ack`, go to ALIGN if `parity` = 1; otherwise go directly to READ.
- `cpu_halt_ack` dropping mid-transfer is ignored; the transfer runs to completion.
- `cpu_halt` = 1 in HALT, ALIGN, READ and WRITE.
- `dma_active` = 1 in ALIGN, READ and WRITE.
- `busy` = 1 in every state except IDLE.
- When `dma_active` = 0: `dma_addr` = 0, `dma_rw` = 1, `dma_data_out` = 0.

## Timing
- Reset values: `cpu_halt` 0, `dma_active` 0, `busy` 0, `dma_addr` 0, `dma_rw` 1, `dma_data_out` 0, state IDLE, `page` 0, `idx` 0, `parity` 0.
- An `nreset` assertion mid-transfer aborts immediately and asynchronously: all outputs return to reset values. No partial write is completed.
- Trigger edge k: HALT is entered at edge k, so `cpu_halt` is high from edge k.
- `peripherals` registers read data on negedge. READ data driven at posedge n is valid at posedge n+1, where WRITE latches it.
- Transfer length after ack: 2·`LENGTH` cycles with even parity, 2·`LENGTH`+1 with odd parity. Default: 512 or 513 cycles.
- Last WRITE is followed by one DONE cycle; `busy` falls on the edge that leaves DONE.

## Configuration
- `OAM_DMA_PARITY_ALIGN_EN` defined: parity check and ALIGN state are compiled in, as described above.
- Not defined: ALIGN state and the parity register are removed; HALT always goes to READ, and every transfer takes exactly 2·`LENGTH` cycles after ack.

## Structure
- Shared package `oam_dma_pkg`:
  - state enum (IDLE, HALT, ALIGN, READ, WRITE, DONE)
  - default constants `OAM_DMA_TRIGGER` = `16'h4014`, `OAM_DMA_DEST` = `16'h2004`
- No sub-module. FSM, index counter and parity toggle live in one module.

## Test plan
- Write `$02` to `$4014`, ack after 1 cycle, memory `$0200+i` = i → 256 writes to `$2004` with data 0..255 in order; `busy` drops after DONE.
- Trigger with `parity` = 0 vs 1 at ack → first READ directly after HALT vs after one ALIGN cycle; total 512 vs 513 cycles (macro defined).
- Hold `cpu_halt_ack` low for 10 cycles → no bus activity, `dma_active` = 0, `cpu_halt` = 1 throughout.
- Second write to `$4014` with `$05` mid-transfer → ignored; source page stays `$02`.
- Assert `nreset` after byte 100 → outputs return to reset values at once; a new trigger restarts from `idx` 0.
- `LENGTH` = 4, page `$01` → reads `$0100`–`$0103` only, then DONE; no carry into page.
